irq_arbiter: RTL
================

# irq_arbiter

Clocked priority resolver and INTA sequencer for the 8259 PIC. It holds the interrupt request register (IRR) and in-service register (ISR), and picks the highest-priority unmasked request under fully nested, rotating priority. It drives INT, runs the two-pulse INTA handshake and places the vector byte on the internal data bus. The control block configures it: mask, trigger mode, rotation, AEOI, EOI pulses, init, vector base.

## Interface
- `IRQ_SYNC`, default 2: synchronizer depth for `ir` and `inta_n` (≥2).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ir`  in  8  raw interrupt request lines IR0–IR7, asynchronous.
- `inta_n`  in  1  CPU interrupt acknowledge, active-low, asynchronous.
- `init`  in  1  ICW1 write pulse (one clk): soft reset of IRR, ISR and FSM.
- `level_edge_triggered`  in  1  1 = level, 0 = edge.
- `int_mask`  in  8  1 = IR masked.
- `priority_rotate`  in  3  number of the lowest-priority IR; highest is (`priority_rotate`+1) mod 8.
- `auto_eoi`  in  1  1 = clear the ISR bit at the end of the INTA sequence.
- `eoi`  in  8  one-clk pulse; each set bit clears the matching ISR bit.
- `vector_base`  in  5  ICW2 T7–T3.
- `int_req`  out  1  INT to CPU.
- `irr`  out  8  interrupt request register.
- `isr`  out  8  in-service register.
- `data_out`  out  8  vector byte.
- `data_out_en`  out  1  bus drive enable for `data_out`.
- `ack_irq`  out  3  IR number acknowledged in the current or last sequence.
- `ack_done`  out  1  one-clk pulse at the end of the sequence.

## Operation
- Reset (`reset_n`=0) or `init`=1 sets:
  - `irr`=0, `isr`=0, state IDLE;
  - `int_req`=0, `data_out`=0, `data_out_en`=0, `ack_irq`=3'b111, `ack_done`=0;
  - edge-detect history to 0, synchronizers to idle (`inta_n`=1).
- Edge mode: an IRR bit sets on a 0→1 transition of the synchronized `ir`. Level mode: an IRR bit sets while the synchronized `ir`=1 and clears when it is 0.
- Priority order: scan from (`priority_rotate`+1) mod 8 upward with wrap-around.
- Candidate: the first bit of `irr & ~int_mask` in priority order, valid only if its priority is strictly higher than every set ISR bit (fully nested).
- FSM states: IDLE, REQ, ACK1, WAIT2, ACK2.
  - IDLE→REQ when a candidate exists; `int_req`←1.
  - REQ→ACK1 on the first synchronized `inta_n` falling edge. On this edge the candidate is re-evaluated (freeze point); `int_req`←0.
    - Candidate W exists: `isr[W]`←1, `irr[W]`←0, `ack_irq`←W.
    - No candidate (request withdrawn or masked meanwhile): spurious. ISR and IRR are unchanged, `ack_irq`←7.
  - ACK1→WAIT2 on synchronized `inta_n` rising edge.
  - WAIT2→ACK2 on the next synchronized falling edge.
  - In ACK2: `data_out`={`vector_base`,`ack_irq`}, `data_out_en`=1.
  - ACK2→IDLE on the rising edge: `data_out_en`←0 and `ack_done` pulses. If `auto_eoi`=1 and not spurious, `isr[ack_irq]`←0 on the same edge.
- In REQ, `int_req` stays 1 even if the candidate vanishes; the spurious path resolves it.
- `inta_n` activity in IDLE is ignored.
- ISR update: next = (`isr` & ~`eoi`) | set_bit. A set in the same cycle wins over a clear of the same bit.
- IRR clear for the winner wins over a same-cycle new edge on that bit; that edge is lost.
- `init` asserted mid-sequence aborts to IDLE on the next edge, with all outputs at their reset values.

## Timing
- `ir` first sampled high at edge k. Then:
  - synchronized at k+`IRQ_SYNC`;
  - `irr` bit set at k+`IRQ_SYNC`+1;
  - `int_req`=1 at k+`IRQ_SYNC`+2 (edge k+4 at the default).
- `inta_n` edges are seen `IRQ_SYNC` clks late. Each INTA low or high phase must last ≥ `IRQ_SYNC`+1 clks.
- `data_out_en` asserts 1 clk after ACK2 entry and deasserts 1 clk after the synchronized rising edge.
- `ack_done` is high for exactly one clk per completed sequence, including spurious ones.
- `eoi` takes effect on the next edge. A freed lower-priority request raises `int_req` one edge later.
- All outputs are registered.

## Test plan
- Edge mode, mask=0, rotate=7: pulse IR3 → `int_req`=1 after 4 clks. Two INTA pulses → `isr`=8'h08, `irr`=0, vector {`vector_base`,3'd3}, `ack_done` one clk.
- IR5 and IR2 raised together, rotate=7: IR2 served first. IR5 raises no `int_req` until `eoi`=8'h04. With rotate=2: IR5 wins over IR2.
- Level mode: IR4 raised, then dropped during REQ before the first INTA → spurious. Vector {base,3'd7}, `isr` unchanged, `ack_irq`=7.
- `auto_eoi`=1: IR1 sequence → `isr[1]` is 1 during WAIT2/ACK2 and 0 after the final INTA rise, on the same edge as `ack_done`.
- `init` pulsed in WAIT2 with `isr`=8'h01 → next edge: state IDLE, `irr`=`isr`=0, `int_req`=0, `data_out_en`=0. A later INTA pulse gives no response.
- Nested: ISR[3] set, IR1 arrives → second sequence sets `isr`=8'h0A. `eoi`=8'h02 leaves 8'h08.

Source files
------------

// File: rtl/irq_arbiter_if.sv
// rtl/irq_arbiter_if.sv - signal bundle between the 8259 control block and irq_arbiter
//
// Purpose: groups the request/acknowledge lines, configuration inputs and
// status outputs of the priority resolver into one bundle.
//
// Port summary (directions seen from the arbiter, i.e. the slave modport):
//   in  ir[7:0]               raw interrupt request lines, asynchronous
//   in  inta_n                CPU interrupt acknowledge, active low, asynchronous
//   in  init                  one-clk soft reset of IRR, ISR and sequencer
//   in  level_edge_triggered  1 = level, 0 = edge
//   in  int_mask[7:0]         1 = IR masked
//   in  priority_rotate[2:0]  lowest-priority IR number
//   in  auto_eoi              clear ISR bit at end of INTA sequence
//   in  eoi[7:0]              one-clk pulse, clears matching ISR bits
//   in  vector_base[4:0]      T7..T3 of the vector byte
//   out int_req               INT to CPU
//   out irr[7:0], isr[7:0]    request / in-service registers
//   out data_out[7:0]         vector byte
//   out data_out_en           bus drive enable for data_out
//   out ack_irq[2:0]          IR number of the current or last sequence
//   out ack_done              one-clk pulse at end of sequence
interface irq_arbiter_if;
  logic [7:0] ir;
  logic       inta_n;
  logic       init;
  logic       level_edge_triggered;
  logic [7:0] int_mask;
  logic [2:0] priority_rotate;
  logic       auto_eoi;
  logic [7:0] eoi;
  logic [4:0] vector_base;

  logic       int_req;
  logic [7:0] irr;
  logic [7:0] isr;
  logic [7:0] data_out;
  logic       data_out_en;
  logic [2:0] ack_irq;
  logic       ack_done;

  modport master (
    output ir, inta_n, init, level_edge_triggered, int_mask,
           priority_rotate, auto_eoi, eoi, vector_base,
    input  int_req, irr, isr, data_out, data_out_en, ack_irq, ack_done
  );

  modport slave (
    input  ir, inta_n, init, level_edge_triggered, int_mask,
           priority_rotate, auto_eoi, eoi, vector_base,
    output int_req, irr, isr, data_out, data_out_en, ack_irq, ack_done
  );
endinterface

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - 8259 priority resolver and two-pulse INTA sequencer
//
// Purpose: holds IRR and ISR, resolves the highest-priority unmasked request
// under fully nested, rotating priority, raises INT and walks the two INTA
// pulses, presenting {vector_base, ack_irq} during the second pulse.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of irq_arbiter_if (see that file for the signals)
//
// Parameter:
//   IRQ_SYNC  synchronizer depth for ir and inta_n (>= 2)
module irq_arbiter #(
  parameter int IRQ_SYNC = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  irq_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ACK1  = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_ACK2  = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizers. Stage 0 is the sampling flop; stage IRQ_SYNC is the
  // synchronized value, so a level sampled at edge k is usable at k+IRQ_SYNC.
  // ---------------------------------------------------------------------------
  logic [IRQ_SYNC:0][7:0] ir_pipe_q;
  logic [IRQ_SYNC:0]      inta_pipe_q;
  logic [7:0]             ir_hist_q;
  logic                   inta_prev_q;

  logic [7:0] ir_s;
  logic       inta_s;
  logic       inta_fall;
  logic       inta_rise;

  assign ir_s      = ir_pipe_q[IRQ_SYNC];
  assign inta_s    = inta_pipe_q[IRQ_SYNC];
  assign inta_fall = inta_prev_q & ~inta_s;
  assign inta_rise = ~inta_prev_q & inta_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_pipe_q   <= '0;
      inta_pipe_q <= '1;
      ir_hist_q   <= '0;
      inta_prev_q <= 1'b1;
    end else if (bus.init) begin
      ir_pipe_q   <= '0;
      inta_pipe_q <= '1;
      ir_hist_q   <= '0;
      inta_prev_q <= 1'b1;
    end else begin
      ir_pipe_q   <= {ir_pipe_q[IRQ_SYNC-1:0], bus.ir};
      inta_pipe_q <= {inta_pipe_q[IRQ_SYNC-1:0], bus.inta_n};
      ir_hist_q   <= ir_s;
      inta_prev_q <= inta_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic       int_req_q, int_req_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_out_en_q, data_out_en_d;
  logic [2:0] ack_irq_q, ack_irq_d;
  logic       ack_done_q, ack_done_d;
  logic       spurious_q, spurious_d;

  // Per-bit update requests produced by the output logic
  logic [7:0] isr_set;
  logic [7:0] isr_aeoi_clr;
  logic [7:0] irr_clr;

  // ---------------------------------------------------------------------------
  // Priority resolution. Rank 0 is the highest priority, i.e. IR number
  // priority_rotate+1; a request wins only if it outranks every ISR bit.
  // ---------------------------------------------------------------------------
  logic [7:0] req_vec;
  logic       cand_found;
  logic [2:0] cand_idx;
  logic [2:0] cand_rank;
  logic       isr_found;
  logic [2:0] isr_rank;
  logic       cand_valid;
  logic [2:0] scan_idx;

  always_comb begin
    req_vec    = irr_q & ~bus.int_mask;
    cand_found = 1'b0;
    cand_idx   = 3'd0;
    cand_rank  = 3'd0;
    isr_found  = 1'b0;
    isr_rank   = 3'd0;
    scan_idx   = 3'd0;
    for (int j = 0; j < 8; j++) begin
      scan_idx = bus.priority_rotate + 3'd1 + 3'(j);
      if (!cand_found && req_vec[scan_idx]) begin
        cand_found = 1'b1;
        cand_idx   = scan_idx;
        cand_rank  = 3'(j);
      end
      if (!isr_found && isr_q[scan_idx]) begin
        isr_found = 1'b1;
        isr_rank  = 3'(j);
      end
    end
    cand_valid = cand_found && (!isr_found || (cand_rank < isr_rank));
  end

  // ---------------------------------------------------------------------------
  // FSM: state register (with all registered outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      irr_q         <= '0;
      isr_q         <= '0;
      int_req_q     <= 1'b0;
      data_out_q    <= '0;
      data_out_en_q <= 1'b0;
      ack_irq_q     <= 3'b111;
      ack_done_q    <= 1'b0;
      spurious_q    <= 1'b0;
    end else if (bus.init) begin
      state_q       <= ST_IDLE;
      irr_q         <= '0;
      isr_q         <= '0;
      int_req_q     <= 1'b0;
      data_out_q    <= '0;
      data_out_en_q <= 1'b0;
      ack_irq_q     <= 3'b111;
      ack_done_q    <= 1'b0;
      spurious_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      irr_q         <= irr_d;
      isr_q         <= isr_d;
      int_req_q     <= int_req_d;
      data_out_q    <= data_out_d;
      data_out_en_q <= data_out_en_d;
      ack_irq_q     <= ack_irq_d;
      ack_done_q    <= ack_done_d;
      spurious_q    <= spurious_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic. INTA activity outside a sequence is ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cand_valid) state_d = ST_REQ;
      ST_REQ:   if (inta_fall)  state_d = ST_ACK1;
      ST_ACK1:  if (inta_rise)  state_d = ST_WAIT2;
      ST_WAIT2: if (inta_fall)  state_d = ST_ACK2;
      ST_ACK2:  if (inta_rise)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    int_req_d     = int_req_q;
    ack_irq_d     = ack_irq_q;
    spurious_d    = spurious_q;
    data_out_d    = 8'h00;
    data_out_en_d = 1'b0;
    ack_done_d    = 1'b0;
    isr_set       = 8'h00;
    isr_aeoi_clr  = 8'h00;
    irr_clr       = 8'h00;
    case (state_q)
      ST_IDLE: int_req_d = cand_valid;
      ST_REQ: begin
        // INT is held even if the candidate disappears; the first INTA
        // falling edge is the freeze point that decides real vs spurious.
        if (inta_fall) begin
          int_req_d = 1'b0;
          if (cand_valid) begin
            isr_set[cand_idx] = 1'b1;
            irr_clr[cand_idx] = 1'b1;
            ack_irq_d         = cand_idx;
            spurious_d        = 1'b0;
          end else begin
            ack_irq_d  = 3'd7;
            spurious_d = 1'b1;
          end
        end
      end
      ST_ACK2: begin
        if (inta_rise) begin
          ack_done_d = 1'b1;
          if (bus.auto_eoi && !spurious_q) isr_aeoi_clr[ack_irq_q] = 1'b1;
        end else begin
          data_out_en_d = 1'b1;
          data_out_d    = {bus.vector_base, ack_irq_q};
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // IRR / ISR next state. The winner's IRR clear overrides a same-cycle new
  // edge on that bit; an ISR set overrides a same-cycle EOI on that bit.
  // ---------------------------------------------------------------------------
  logic [7:0] ir_new_edge;

  always_comb begin
    ir_new_edge = ir_s & ~ir_hist_q;
    if (bus.level_edge_triggered) irr_d = ir_s & ~irr_clr;
    else                          irr_d = (irr_q | ir_new_edge) & ~irr_clr;
    isr_d = (isr_q & ~bus.eoi & ~isr_aeoi_clr) | isr_set;
  end

  assign bus.int_req     = int_req_q;
  assign bus.irr         = irr_q;
  assign bus.isr         = isr_q;
  assign bus.data_out    = data_out_q;
  assign bus.data_out_en = data_out_en_q;
  assign bus.ack_irq     = ack_irq_q;
  assign bus.ack_done    = ack_done_q;

endmodule
